ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 157 +++++++++++++++
 tb/tb_ifetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch: PC generation, epoch-tagged outstanding requests and an in-order fetch queue.
// Define IFETCH_ALIGN_CHECK_EN to halt with a sticky fetch_fault on a misaligned redirect.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FQ_DEPTH);

`ifdef IFETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_HALT} state_t;
`else
    typedef enum logic [1:0] {ST_RESET, ST_RUN} state_t;
`endif

    state_t           state;
    logic [31:0]      pc;
    logic             epoch;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] q_count;
    logic [PTR_W-1:0] tag_wr;
    logic [PTR_W-1:0] tag_rd;
    logic [PTR_W-1:0] q_wr;
    logic [PTR_W-1:0] q_rd;

    logic             tag_epoch [FQ_DEPTH];
    logic [31:0]      tag_addr  [FQ_DEPTH];
    logic [31:0]      q_data    [FQ_DEPTH];
    logic [31:0]      q_pc      [FQ_DEPTH];

    logic             req_fire;
    logic             rsp_fire;
    logic             enq;
    logic             pop;
    logic [31:0]      target;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic             fault;
    logic             misaligned;

    assign misaligned  = (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = fault;
`else
    assign fetch_fault = 1'b0;
`endif

    assign target = redirect_pc & 32'hFFFF_FFFC;

    // Credit check: every outstanding request owns a free queue slot.
    assign imem_req_valid = (state == ST_RUN) && ((outstanding + q_count) < DEPTH_CNT);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (outstanding != '0);

    // Responses from an older epoch, or arriving alongside a redirect, are discarded.
    assign enq = rsp_fire && !redirect && (tag_epoch[tag_rd] == epoch);

    assign inst_valid = (q_count != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = inst_valid ? q_data[q_rd] : 32'h0;
    assign inst_pc    = inst_valid ? q_pc[q_rd]   : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RESET;
            pc          <= RESET_PC;
            epoch       <= 1'b0;
            outstanding <= '0;
            q_count     <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault       <= 1'b0;
`endif
        end else begin
            if (state == ST_RESET) begin
                state <= ST_RUN;
            end

            if (req_fire) begin
                pc     <= pc + 32'd4;
                tag_wr <= tag_wr + 1'b1;
            end

            if (rsp_fire) begin
                tag_rd <= tag_rd + 1'b1;
            end

            case ({req_fire, rsp_fire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase

            if (enq) begin
                q_wr <= q_wr + 1'b1;
            end

            // A pop in the redirect cycle still counts as consumed; the queue empties either way.
            if (redirect) begin
                epoch   <= ~epoch;
                pc      <= target;
                q_count <= '0;
                q_rd    <= q_wr;
`ifdef IFETCH_ALIGN_CHECK_EN
                if (misaligned) begin
                    state <= ST_HALT;
                    fault <= 1'b1;
                end else begin
                    state <= ST_RUN;
                    fault <= 1'b0;
                end
`endif
            end else begin
                if (pop) begin
                    q_rd <= q_rd + 1'b1;
                end
                case ({enq, pop})
                    2'b10:   q_count <= q_count + 1'b1;
                    2'b01:   q_count <= q_count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_epoch[tag_wr] <= epoch;
            tag_addr[tag_wr]  <= pc;
        end
        if (enq) begin
            q_data[q_wr] <= imem_rsp_data;
            q_pc[q_wr]   <= tag_addr[tag_rd];
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: memory responder model plus a PC/data scoreboard on the decode side.
// Builds against either setting of IFETCH_ALIGN_CHECK_EN.
module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FQ_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .fetch_fault(fetch_fault)
    );

    int total = 0;
    int bad = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
    endfunction

    // Memory side: requests queued in order, answered one per cycle unless held.
    logic [31:0] mem_q[$];
    logic        mem_hold = 1'b0;
    int          mem_rsp_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                mem_q.delete();
                mem_rsp_cnt = 0;
                imem_rsp_valid = 1'b0;
                imem_rsp_data = 32'h0;
            end else if (!mem_hold && mem_q.size() != 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = memData(mem_q.pop_front());
                mem_rsp_cnt++;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data = 32'h0;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Scoreboard: expected PCs pushed on each handshake, dropped on redirect, popped on decode accept.
    logic [31:0] sb_pc[$];
    logic [31:0] pop_log[$];
    logic [31:0] mdl_pc = RESET_PC;
    logic        redir_last = 1'b0;
    int          hs_cnt = 0;
    int          first_hs = -1;
    int          first_valid = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            redir_last = 1'b0;
        end else begin
            if (redir_last) checkOutput("flush_valid", inst_valid, 0);
            if (inst_valid && first_valid < 0) first_valid = cyc;
            if (inst_valid && inst_ready) begin
                pop_log.push_back(inst_pc);
                checkOutput("sb_nonempty", sb_pc.size() != 0, 1);
                if (sb_pc.size() != 0) begin
                    logic [31:0] e;
                    e = sb_pc.pop_front();
                    checkOutput("inst_pc", inst_pc, e);
                    checkOutput("inst_data", inst_data, memData(e));
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = cyc;
                checkOutput("req_addr", imem_req_addr, mdl_pc);
                mem_q.push_back(imem_req_addr);
                if (!redirect) sb_pc.push_back(mdl_pc);
                mdl_pc = mdl_pc + 32'd4;
            end
            if (redirect) begin
                sb_pc.delete();
                mdl_pc = redirect_pc & 32'hFFFF_FFFC;
            end
            redir_last = redirect;
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ir, input logic rr, input logic hold,
                                 input logic rd, input logic [31:0] rpc);
        inst_ready = ir;
        imem_req_ready = rr;
        mem_hold = hold;
        redirect = rd;
        redirect_pc = rpc;
    endtask

    task automatic applyReset();
        stepCycle();
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 32'h0);
        #1;
        checkOutput("rst_req_valid", imem_req_valid, 0);
        checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
        checkOutput("rst_inst_valid", inst_valid, 0);
        checkOutput("rst_inst_data", inst_data, 0);
        checkOutput("rst_inst_pc", inst_pc, 0);
        checkOutput("rst_fault", fetch_fault, 0);
        sb_pc.delete();
        pop_log.delete();
        mdl_pc = RESET_PC;
        hs_cnt = 0;
        first_hs = -1;
        first_valid = -1;
        repeat (2) stepCycle();
        rst_n = 1'b1;
    endtask

    task automatic waitPops(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && pop_log.size() < n; i++) stepCycle();
        checkOutput(tag, pop_log.size() >= n, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int hs_base;
        logic found;
        logic [31:0] rpc;

        // Streaming start-up and first-instruction latency
        applyReset();
        applyStimulus(1, 1, 0, 0, 32'h0);
        waitPops(3, 40, "t20_pops");
        checkOutput("t20_latency", first_valid - first_hs, 2);
        if (pop_log.size() >= 3) begin
            checkOutput("t20_pc0", pop_log[0], 32'h0);
            checkOutput("t20_pc1", pop_log[1], 32'h4);
            checkOutput("t20_pc2", pop_log[2], 32'h8);
        end

        // Decode stalled: request credit limited to the queue depth
        applyReset();
        applyStimulus(0, 1, 0, 0, 32'h0);
        repeat (20) stepCycle();
        checkOutput("t21_hs_cnt", hs_cnt, FQ_DEPTH);
        checkOutput("t21_req_valid", imem_req_valid, 0);
        applyStimulus(1, 1, 0, 0, 32'h0);
        stepCycle();
        applyStimulus(0, 1, 0, 0, 32'h0);
        for (int i = 0; i < 10 && hs_cnt < FQ_DEPTH + 1; i++) stepCycle();
        checkOutput("t21_resume", hs_cnt, FQ_DEPTH + 1);
        repeat (10) stepCycle();
        checkOutput("t21_hs_final", hs_cnt, FQ_DEPTH + 1);

        // Redirect with two requests in flight
        applyReset();
        applyStimulus(0, 1, 1, 0, 32'h0);
        repeat (6) stepCycle();
        checkOutput("t22_inflight", hs_cnt, 2);
        applyStimulus(0, 1, 1, 1, 32'h100);
        stepCycle();
        applyStimulus(1, 1, 0, 0, 32'h0);
        waitPops(3, 40, "t22_pops");
        if (pop_log.size() >= 1) checkOutput("t22_first_pc", pop_log[0], 32'h100);

        // Redirect coinciding with a handshake at 0x8 and the response for 0x4
        applyReset();
        applyStimulus(1, 1, 0, 0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            stepCycle();
            if (imem_req_valid && imem_req_addr == 32'h8) begin
                applyStimulus(1, 1, 0, 1, 32'h40);
                found = 1'b1;
                #2;
                checkOutput("t23_rsp_coincide", imem_rsp_valid, 1);
            end else begin
                applyStimulus(1, 1, mem_rsp_cnt >= 1, 0, 32'h0);
            end
        end
        checkOutput("t23_found", found, 1);
        base = pop_log.size();
        stepCycle();
        applyStimulus(1, 1, 0, 0, 32'h0);
        waitPops(base + 2, 40, "t23_pops");
        if (pop_log.size() >= base + 2) begin
            checkOutput("t23_first_pc", pop_log[base], 32'h40);
            checkOutput("t23_second_pc", pop_log[base + 1], 32'h44);
        end

        // Misaligned redirect
        applyReset();
        applyStimulus(1, 1, 0, 0, 32'h0);
        repeat (5) stepCycle();
        applyStimulus(1, 1, 0, 1, 32'h102);
        stepCycle();
        applyStimulus(1, 1, 0, 0, 32'h0);
        base = pop_log.size();
`ifdef IFETCH_ALIGN_CHECK_EN
        checkOutput("t24_fault_set", fetch_fault, 1);
        hs_base = hs_cnt;
        repeat (10) stepCycle();
        checkOutput("t24_no_req", hs_cnt, hs_base);
        checkOutput("t24_req_valid", imem_req_valid, 0);
        checkOutput("t24_fault_sticky", fetch_fault, 1);
        applyStimulus(1, 1, 0, 1, 32'h200);
        stepCycle();
        applyStimulus(1, 1, 0, 0, 32'h0);
        checkOutput("t24_fault_clear", fetch_fault, 0);
        base = pop_log.size();
        waitPops(base + 2, 40, "t24_pops");
        if (pop_log.size() >= base + 1) checkOutput("t24_first_pc", pop_log[base], 32'h200);
`else
        checkOutput("t24_fault_tied", fetch_fault, 0);
        hs_base = hs_cnt;
        waitPops(base + 2, 40, "t24_pops");
        if (pop_log.size() >= base + 1) checkOutput("t24_first_pc", pop_log[base], 32'h100);
        checkOutput("t24_fault_tied2", fetch_fault, 0);
        checkOutput("t24_fetching", hs_cnt > hs_base, 1);
`endif

        // Randomised traffic with occasional redirects
        applyReset();
        for (int i = 0; i < 400; i++) begin
            stepCycle();
`ifdef IFETCH_ALIGN_CHECK_EN
            rpc = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
`else
            rpc = 32'h1000 + 32'($urandom_range(0, 255));
`endif
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, rpc);
        end
        stepCycle();
        applyStimulus(1, 1, 0, 0, 32'h0);
        repeat (10) stepCycle();
        checkOutput("rand_pops", pop_log.size() > 40, 1);

        // Reset pulsed mid-stream
        applyReset();
        applyStimulus(1, 1, 0, 0, 32'h0);
        repeat (15) stepCycle();
        checkOutput("t25_streaming", pop_log.size() > 0, 1);
        applyReset();
        applyStimulus(1, 1, 0, 0, 32'h0);
        waitPops(2, 40, "t25_pops");
        if (pop_log.size() >= 1) checkOutput("t25_restart_pc", pop_log[0], RESET_PC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
